riscv_lsu_mem: RTL and testbench
================================

Name: riscv_lsu_mem

Overview:
Banked data memory with an RV32I load/store front end, sitting between the execute stage and the data RAM.
- Accepts one request per transaction over a valid/ready handshake.
- Decodes funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW), drives per-byte bank enables, and aligns and sign-extends load data.
- Returns every request (load or store) as a response carrying data or an error flag.
- Successor to the fixed 32-bit/4-RAM setup: width, bank count, depth and read latency are parameters.

Parameters:
DATA_WIDTH, 32, data bus width; must equal 8*RAM_AMOUNT
RAM_AMOUNT, 4, number of byte-wide banks (one per byte lane)
DEPTH, 1024, words per bank
RD_LATENCY, 1, bank read latency in cycles (1..4)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready
rsp_rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned, illegal funct3 or out-of-range address
perf_loads  out  32  completed loads (feature only)
perf_stores  out  32  completed stores (feature only)
perf_errs  out  32  error responses (feature only)

Behaviour:
- Reset (rst_n=0 at clk edge): FSM->IDLE; req_ready=0 during reset, 1 in the first IDLE cycle after; rsp_valid=0, rsp_rdata=0, rsp_err=0, perf counters=0. Bank contents are not cleared.
- Reset mid-transaction aborts it: no response is issued. A store already committed to the banks stays written.
- FSM states IDLE, READ, RESP:
  - IDLE: req_ready=1. On accept, latch we, funct3, addr and wdata, then check for errors.
  - Error, or store: go to RESP next cycle. A legal store writes the banks on the accept edge.
  - Legal load: go to READ, counter=RD_LATENCY-1.
  - READ: req_ready=0. Decrement the counter; at 0, capture and extend bank data and go to RESP.
  - RESP: rsp_valid=1, outputs held stable until rsp_ready; then back to IDLE. No back-to-back accept in the same cycle.
- Latency from accept edge to rsp_valid: load = RD_LATENCY+1 cycles; store or error = 1 cycle.
- Error rules, checked in priority order illegal > range > misaligned:
  - Illegal funct3: loads 011/110/111; stores >=011.
  - Out of range: addr >= DEPTH*RAM_AMOUNT.
  - Misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0.
  - On error: no bank access, rsp_err=1, rsp_rdata=0.
- Bank select: word index = addr >> log2(RAM_AMOUNT); lane = addr[log2(RAM_AMOUNT)-1:0].
  - SB: enable lane only. SH: lanes lane and lane+1. SW: all lanes.
  - Store data is replicated across lanes.
- Load extension: LB/LH sign-extend bit 7/15 to DATA_WIDTH; LBU/LHU zero-extend; LW passes the full word.
- Simultaneous events: req_valid arriving while in READ/RESP is stalled (req_ready=0). rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
RISCV_LSU_PERF_CNT_EN
- Defined: three 32-bit counters, each incremented on the RESP handshake (rsp_valid&&rsp_ready).
  - perf_errs increments if rsp_err=1; otherwise perf_loads or perf_stores per the latched we.
  - Counters wrap 0xFFFFFFFF->0.
- Undefined: counter logic is absent; perf_* ports tied to 0.

Decomposition:
- Shared package (existing definitions package):
  - lsu_funct3_e: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
  - lsu_state_e: IDLE/READ/RESP.
  - Constant LANE_BITS=$clog2(RAM_AMOUNT).
  - Reuses DATA_WIDTH, RAM_AMOUNT and dataBus_t.
- Sub-module riscv_mem_bank: one byte-wide synchronous RAM with parameters DEPTH and RD_LATENCY; ports en, we, addr, wdata, rdata. Instantiated RAM_AMOUNT times via generate.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> store rsp err=0 rdata=0; load rsp 1+RD_LATENCY cycles after accept, rdata=0xDEADBEEF.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; only lane 1 was enabled.
- LW 0x11, SH 0x03, funct3=011 load, LW 0x1000 (DEPTH=1024) -> each rsp_err=1, rdata=0, 1-cycle latency, memory unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid and data stable, req_ready=0; accept resumes the cycle after the rsp handshake.
- Assert rst_n=0 during READ -> next cycle rsp_valid=0, req_ready=0; IDLE after release; with RISCV_LSU_PERF_CNT_EN, 2 loads + 1 store + 1 error -> counters 2/1/1.

Source files
------------

// File: rtl/riscv_lsu_mem_pkg.sv
// Shared definitions for the RV32I load/store unit and its banked data memory.
// Holds funct3 encodings, LSU FSM states and the default bus geometry.
package riscv_lsu_mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int RAM_AMOUNT = 4;
    localparam int LANE_BITS  = $clog2(RAM_AMOUNT);

    typedef logic [DATA_WIDTH-1:0] dataBus_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } lsu_st_funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } lsu_state_e;

    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 >= 3'b011;
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/riscv_lsu_mem_bank.sv
// One byte-wide synchronous RAM bank with a configurable read pipeline.
// Contents are never reset; rdata holds the last read until shifted out.
module riscv_mem_bank #(
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem  [DEPTH];
    logic [7:0] pipe [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[addr] <= wdata;
        if (en && !we)
            pipe[0] <= mem[addr];
        for (int i = 1; i < RD_LATENCY; i++)
            pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[RD_LATENCY-1];

endmodule

// File: rtl/riscv_lsu_mem.sv
// RV32I load/store front end over RAM_AMOUNT byte banks.
// Optional RISCV_LSU_PERF_CNT_EN adds load/store/error response counters.
import riscv_lsu_mem_pkg::*;

module riscv_lsu_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_AMOUNT = 4,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [31:0]           perf_loads,
    output logic [31:0]           perf_stores,
    output logic [31:0]           perf_errs
);

    localparam int LANE_W = $clog2(RAM_AMOUNT);
    localparam int AW     = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH * RAM_AMOUNT);

    lsu_state_e            state;
    logic [2:0]            cnt;
    logic [2:0]            lat_f3;
    logic [LANE_W-1:0]     lat_lane;
    logic                  accept;
    logic                  acc_err;
    logic [1:0]            size;
    logic [LANE_W-1:0]     lane;
    logic [RAM_AMOUNT-1:0] mask;
    logic [DATA_WIDTH-1:0] wrep;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_ext;

    assign accept = rst_n && req_valid && req_ready;
    assign size   = req_funct3[1:0];
    assign lane   = req_addr[LANE_W-1:0];

    always_comb begin
        acc_err = lsu_illegal(req_we, req_funct3)
               || ({1'b0, req_addr} >= MEM_BYTES)
               || (size == 2'b01 && req_addr[0])
               || (size == 2'b10 && lane != '0);
    end

    always_comb begin
        mask = '1;
        wrep = req_wdata;
        unique case (1'b1)
            size == 2'b00: begin
                mask = RAM_AMOUNT'(1) << lane;
                wrep = {RAM_AMOUNT{req_wdata[7:0]}};
            end
            size == 2'b01: begin
                mask = RAM_AMOUNT'(3) << lane;
                wrep = {(RAM_AMOUNT/2){req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    for (genvar g = 0; g < RAM_AMOUNT; g++) begin : g_bank
        riscv_mem_bank #(
            .DEPTH      (DEPTH),
            .RD_LATENCY (RD_LATENCY)
        ) u_bank (
            .clk   (clk),
            .en    (accept && !acc_err && mask[g]),
            .we    (req_we),
            .addr  (req_addr[LANE_W +: AW]),
            .wdata (wrep[8*g +: 8]),
            .rdata (bank_rdata[8*g +: 8])
        );
    end

    // Lane-align the fetched word, then extend by the latched load type.
    always_comb begin
        shifted  = bank_rdata >> {lat_lane, 3'b000};
        load_ext = shifted;
        case (lat_f3)
            LB:      load_ext = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            LH:      load_ext = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            LBU:     load_ext = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            LHU:     load_ext = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_ext = bank_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            lat_f3    <= '0;
            lat_lane  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        lat_f3    <= req_funct3;
                        lat_lane  <= lane;
                        req_ready <= 1'b0;
                        if (acc_err || req_we) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= acc_err;
                            rsp_rdata <= '0;
                        end else begin
                            state <= READ;
                            cnt   <= 3'(RD_LATENCY - 1);
                        end
                    end
                end
                READ: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RISCV_LSU_PERF_CNT_EN
    logic lat_we;

    always_ff @(posedge clk) begin
        if (!rst_n)
            lat_we <= 1'b0;
        else if (accept)
            lat_we <= req_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (rsp_err)
                perf_errs <= perf_errs + 32'd1;
            else if (lat_we)
                perf_stores <= perf_stores + 32'd1;
            else
                perf_loads <= perf_loads + 32'd1;
        end
    end
`else
    assign perf_loads  = '0;
    assign perf_stores = '0;
    assign perf_errs   = '0;
`endif

endmodule

// File: tb/tb_riscv_lsu_mem.sv
// Directed self-checking bench for riscv_lsu_mem (default geometry).
// Expected values are hand-computed from the load/store semantics.
module tb_riscv_lsu_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errs;

    int checks = 0;
    int errors = 0;

    riscv_lsu_mem #(
        .DATA_WIDTH (32),
        .RAM_AMOUNT (4),
        .DEPTH      (1024),
        .RD_LATENCY (1),
        .ADDR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_errs   (perf_errs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its response and consume it.
    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        if (!req_ready)
            check("req_ready_timeout", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!rsp_valid)
            check("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic do_rst();
        rst_n = 1'b0;
        step();
        step();
        check("rst_req_ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();
    endtask

    typedef struct {
        string       tag;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] held;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;

        do_rst();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_perf_loads", perf_loads, 32'd0);

        vecs = '{
            '{"sw_10",   1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1},
            '{"lw_10",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2},
            '{"lb_13",   1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2},
            '{"lbu_13",  1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2},
            '{"lh_10",   1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0, 2},
            '{"lhu_12",  1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 2},
            '{"sb_11",   1'b1, 3'b000, 32'h11,   32'h00000055, 32'h0,        1'b0, 1},
            '{"lw_sb",   1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2},
            '{"sw_00",   1'b1, 3'b010, 32'h0,    32'h11223344, 32'h0,        1'b0, 1},
            '{"lw_mis",  1'b0, 3'b010, 32'h11,   32'h0,        32'h0,        1'b1, 1},
            '{"sh_mis",  1'b1, 3'b001, 32'h03,   32'h0000AAAA, 32'h0,        1'b1, 1},
            '{"ld_ill",  1'b0, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1, 1},
            '{"st_ill",  1'b1, 3'b100, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1, 1},
            '{"lw_rng",  1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1, 1},
            '{"sw_rng",  1'b1, 3'b010, 32'h1000, 32'h12345678, 32'h0,        1'b1, 1},
            '{"lw_00",   1'b0, 3'b010, 32'h0,    32'h0,        32'h11223344, 1'b0, 2},
            '{"lw_keep", 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0, 2},
            '{"sh_12",   1'b1, 3'b001, 32'h12,   32'h00001234, 32'h0,        1'b0, 1},
            '{"lw_sh",   1'b0, 3'b010, 32'h10,   32'h0,        32'h123455EF, 1'b0, 2},
            '{"lh_12",   1'b0, 3'b001, 32'h12,   32'h0,        32'h00001234, 1'b0, 2}
        };

        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            check({vecs[i].tag, "_rdata"}, rd, vecs[i].exp_rd);
            check({vecs[i].tag, "_err"}, 32'(er), 32'(vecs[i].exp_err));
            check({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Response back-pressure with a new request already waiting.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        step();
        req_funct3 = 3'b100;
        req_addr   = 32'h11;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        held = rsp_rdata;
        check("stall_rdata", held, 32'h123455EF);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_hold", rsp_rdata, held);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("stall_rsp_drop", 32'(rsp_valid), 32'd0);
        check("stall_resume", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        check("stall_next_lat", 32'(lat), 32'd2);
        check("stall_next_rdata", rsp_rdata, 32'h00000055);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Reset while a load sits in READ.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        step();
        req_valid = 1'b0;
        check("abort_in_read", 32'(rsp_valid | req_ready), 32'd0);
        rst_n = 1'b0;
        step();
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("abort_idle", 32'(req_ready), 32'd1);
        step();
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);

        xact(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        check("perf_ld1", rd, 32'h123455EF);
        xact(1'b1, 3'b000, 32'h20, 32'h000000A5, rd, er, lat);
        check("perf_st", 32'(er), 32'd0);
        xact(1'b0, 3'b000, 32'h20, 32'h0, rd, er, lat);
        check("perf_ld2", rd, 32'hFFFFFFA5);
        xact(1'b0, 3'b001, 32'h21, 32'h0, rd, er, lat);
        check("perf_errld", 32'(er), 32'd1);
`ifdef RISCV_LSU_PERF_CNT_EN
        check("perf_loads", perf_loads, 32'd2);
        check("perf_stores", perf_stores, 32'd1);
        check("perf_errs", perf_errs, 32'd1);
`else
        check("perf_loads_off", perf_loads, 32'd0);
        check("perf_stores_off", perf_stores, 32'd0);
        check("perf_errs_off", perf_errs, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
